// File: rtl/gmii_pkg.sv
// Shared types and constants for the GMII/MII receive-side symbol generator.
// The FCS state exists only when GMII_PHY_RX_GEN_FCS_EN is defined.
package gmii_pkg;

  typedef enum logic [1:0] {
    SPD_10    = 2'b00,
    SPD_100   = 2'b01,
    SPD_1000  = 2'b10,
    SPD_1000B = 2'b11
  } speed_e;

  // state    | meaning
  // IDLE     | waiting for a strobe with tvalid
  // PREAMBLE | PREAMBLE_LEN bytes of 0x55
  // SFD      | one 0xD5 byte
  // DATA     | payload bytes; drain_q set while discarding after an underflow
  // FCS      | four CRC-32 bytes, LSB first
  // IFG      | IFG_LEN idle byte times
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_SFD,
    ST_DATA,
`ifdef GMII_PHY_RX_GEN_FCS_EN
    ST_FCS,
`endif
    ST_IFG
  } state_e;

  localparam logic [7:0] ETH_PRE = 8'h55;
  localparam logic [7:0] ETH_SFD = 8'hD5;

  localparam int PRESCALE_1000 = 1;
  localparam int PRESCALE_100  = 5;
  localparam int PRESCALE_10   = 50;

  function automatic logic [5:0] prescale_of(input speed_e s);
    case (s)
      SPD_10:  return 6'(PRESCALE_10);
      SPD_100: return 6'(PRESCALE_100);
      default: return 6'(PRESCALE_1000);
    endcase
  endfunction

  function automatic logic is_mii(input speed_e s);
    return (s == SPD_10) || (s == SPD_100);
  endfunction

endpackage

// File: rtl/lfsr.sv
// Byte-parallel reflected (LSB-first) Galois LFSR, used as the CRC-32 engine.
// Compiled only when GMII_PHY_RX_GEN_FCS_EN is defined.
`ifdef GMII_PHY_RX_GEN_FCS_EN
module lfsr #(
  parameter int               WIDTH  = 32,
  parameter logic [WIDTH-1:0] POLY   = 32'h04C1_1DB7,
  parameter logic [WIDTH-1:0] INIT   = 32'hFFFF_FFFF,
  parameter int               DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [WIDTH-1:0]  state_o
);

  logic [WIDTH-1:0] state_q, state_d, poly_rev;

  for (genvar g = 0; g < WIDTH; g++) begin : g_rev
    assign poly_rev[g] = POLY[WIDTH-1-g];
  end

  always_comb begin
    state_d = state_q;
    for (int i = 0; i < DATA_W; i++) begin
      if (state_d[0] ^ data_i[i]) state_d = (state_d >> 1) ^ poly_rev;
      else                        state_d = state_d >> 1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         state_q <= INIT;
    else if (init_i) state_q <= INIT;
    else if (en_i)   state_q <= state_d;
  end

  assign state_o = state_q;

endmodule
`endif

// File: rtl/gmii_phy_rx_gen.sv
// Turns an AXI-stream frame into PHY-to-MAC GMII/MII receive symbols at 10/100/1000 Mb/s.
// Define GMII_PHY_RX_GEN_FCS_EN to append a CRC-32 FCS after the payload.
module gmii_phy_rx_gen
  import gmii_pkg::*;
#(
  parameter int PREAMBLE_LEN = 7,
  parameter int IFG_LEN      = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  input  logic       s_axis_tlast,
  input  logic       s_axis_tuser,
  input  logic [1:0] speed,
  output logic [7:0] gmii_rxd,
  output logic       gmii_rx_dv,
  output logic       gmii_rx_er,
  output logic       gmii_clk_en,
  output logic       mii_select,
  output logic       busy,
  output logic       error_underflow
);

  state_e     state_q;
  speed_e     spd_q, spd_d;
  logic [5:0] cnt_q, cnt_d;
  logic [7:0] bcnt_q, byte_q, rxd_q;
  logic       nib_q, drain_q, dv_q, er_q, clk_en_q, unf_q;
  logic       strobe, byte_start;
  logic       emit_en, emit_dv, emit_er, underflow;
  logic [7:0] emit_byte;

  assign strobe     = (cnt_q == 6'd0);
  assign byte_start = strobe && !nib_q;

  assign spd_d = (state_q == ST_IDLE && byte_start && s_axis_tvalid) ? speed_e'(speed) : spd_q;
  assign cnt_d = strobe ? prescale_of(spd_d) - 6'd1 : cnt_q - 6'd1;

  assign s_axis_tready = (state_q == ST_DATA) && (drain_q || byte_start);

`ifdef GMII_PHY_RX_GEN_FCS_EN
  logic [31:0] crc_w, fcs_w;
  logic [7:0]  fcs_byte;

  lfsr #(
    .WIDTH (32),
    .POLY  (32'h04C1_1DB7),
    .INIT  (32'hFFFF_FFFF),
    .DATA_W(8)
  ) u_crc (
    .clk    (clk),
    .rst    (rst),
    .init_i (state_q == ST_SFD && byte_start),
    .en_i   (s_axis_tready && s_axis_tvalid && !drain_q),
    .data_i (s_axis_tdata),
    .state_o(crc_w)
  );

  // bcnt_q runs 3..0, so byte 3-bcnt of the inverted CRC goes out LSB first
  assign fcs_w    = ~crc_w;
  assign fcs_byte = fcs_w[{2'd3 - bcnt_q[1:0], 3'b000} +: 8];
`endif

  always_comb begin
    emit_en   = 1'b0;
    emit_byte = 8'h00;
    emit_dv   = 1'b0;
    emit_er   = 1'b0;
    underflow = 1'b0;
    if (byte_start) begin
      case (state_q)
        ST_PREAMBLE: begin emit_en = 1'b1; emit_byte = ETH_PRE; emit_dv = 1'b1; end
        ST_SFD:      begin emit_en = 1'b1; emit_byte = ETH_SFD; emit_dv = 1'b1; end
        ST_DATA: begin
          emit_en = 1'b1;
          if (!drain_q) begin
            emit_dv = 1'b1;
            if (s_axis_tvalid) begin
              emit_byte = s_axis_tdata;
              emit_er   = s_axis_tlast & s_axis_tuser;
            end else begin
              emit_er   = 1'b1;
              underflow = 1'b1;
            end
          end
        end
`ifdef GMII_PHY_RX_GEN_FCS_EN
        ST_FCS:      begin emit_en = 1'b1; emit_byte = fcs_byte; emit_dv = 1'b1; end
`endif
        ST_IFG:      emit_en = 1'b1;
        default:     ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      spd_q    <= SPD_1000;
      cnt_q    <= 6'd0;
      bcnt_q   <= 8'd0;
      byte_q   <= 8'd0;
      nib_q    <= 1'b0;
      drain_q  <= 1'b0;
      rxd_q    <= 8'd0;
      dv_q     <= 1'b0;
      er_q     <= 1'b0;
      clk_en_q <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      spd_q    <= spd_d;
      clk_en_q <= strobe;
      unf_q    <= underflow;

      // second half of a nibble-mode byte: dv/er keep the value set for the byte
      if (strobe && nib_q) begin
        rxd_q <= {4'h0, byte_q[7:4]};
        nib_q <= 1'b0;
      end else if (emit_en) begin
        dv_q <= emit_dv;
        er_q <= emit_er;
        if (is_mii(spd_q)) begin
          rxd_q  <= {4'h0, emit_byte[3:0]};
          byte_q <= emit_byte;
          nib_q  <= 1'b1;
        end else begin
          rxd_q <= emit_byte;
        end
      end

      case (state_q)
        ST_IDLE: if (byte_start && s_axis_tvalid) begin
          state_q <= ST_PREAMBLE;
          bcnt_q  <= 8'(PREAMBLE_LEN - 1);
        end
        ST_PREAMBLE: if (byte_start) begin
          if (bcnt_q == 8'd0) state_q <= ST_SFD;
          else                bcnt_q  <= bcnt_q - 8'd1;
        end
        ST_SFD: if (byte_start) begin
          state_q <= ST_DATA;
          drain_q <= 1'b0;
        end
        ST_DATA: begin
          if (drain_q) begin
            if (s_axis_tvalid && s_axis_tlast) begin
              state_q <= ST_IFG;
              bcnt_q  <= 8'(IFG_LEN - 1);
              drain_q <= 1'b0;
            end
          end else if (byte_start) begin
            if (!s_axis_tvalid) begin
              drain_q <= 1'b1;
            end else if (s_axis_tlast) begin
`ifdef GMII_PHY_RX_GEN_FCS_EN
              state_q <= ST_FCS;
              bcnt_q  <= 8'd3;
`else
              state_q <= ST_IFG;
              bcnt_q  <= 8'(IFG_LEN - 1);
`endif
            end
          end
        end
`ifdef GMII_PHY_RX_GEN_FCS_EN
        ST_FCS: if (byte_start) begin
          if (bcnt_q == 8'd0) begin
            state_q <= ST_IFG;
            bcnt_q  <= 8'(IFG_LEN - 1);
          end else begin
            bcnt_q <= bcnt_q - 8'd1;
          end
        end
`endif
        ST_IFG: if (byte_start) begin
          if (bcnt_q == 8'd0) state_q <= ST_IDLE;
          else                bcnt_q  <= bcnt_q - 8'd1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign gmii_rxd        = rxd_q;
  assign gmii_rx_dv      = dv_q;
  assign gmii_rx_er      = er_q;
  assign gmii_clk_en     = clk_en_q;
  assign error_underflow = unf_q;
  assign mii_select      = is_mii(spd_q);
  assign busy            = (state_q != ST_IDLE) || nib_q;

endmodule

// File: tb/tb_gmii_phy_rx_gen.sv
// Self-checking bench for gmii_phy_rx_gen: directed plus random frames against a symbol-list model.
// Honours GMII_PHY_RX_GEN_FCS_EN to expect the appended CRC-32.
module tb_gmii_phy_rx_gen;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [7:0] rxd;
    logic       er;
    logic       dc;
  } sym_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] s_axis_tdata = 8'h00;
  logic       s_axis_tvalid = 1'b0;
  logic       s_axis_tready;
  logic       s_axis_tlast = 1'b0;
  logic       s_axis_tuser = 1'b0;
  logic [1:0] speed = 2'b10;
  logic [7:0] gmii_rxd;
  logic       gmii_rx_dv, gmii_rx_er, gmii_clk_en, mii_select, busy, error_underflow;

  gmii_phy_rx_gen dut (
    .clk            (clk),
    .rst            (rst),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .s_axis_tlast   (s_axis_tlast),
    .s_axis_tuser   (s_axis_tuser),
    .speed          (speed),
    .gmii_rxd       (gmii_rxd),
    .gmii_rx_dv     (gmii_rx_dv),
    .gmii_rx_er     (gmii_rx_er),
    .gmii_clk_en    (gmii_clk_en),
    .mii_select     (mii_select),
    .busy           (busy),
    .error_underflow(error_underflow)
  );

  always #4 clk = ~clk;

  int   n_cmp = 0;
  int   n_err = 0;
  sym_t got_q[$];
  sym_t exp_q[$];
  int   frames_done = 0;
  int   tready_cnt = 0;
  int   unf_cnt = 0;
  int   cyc = 0;
  int   last_stb = -1;
  int   sp_min = 999;
  int   sp_max = 0;
  bit   in_frame = 0;

  // monitor: every strobe with dv=1 is a frame symbol; the first dv=0 strobe closes the frame
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      in_frame = 0;
      last_stb = -1;
    end else begin
      if (s_axis_tready) tready_cnt++;
      if (error_underflow) unf_cnt++;
      if (gmii_clk_en) begin
        if (gmii_rx_dv) begin
          got_q.push_back('{gmii_rxd, gmii_rx_er, 1'b0});
          if (last_stb >= 0) begin
            if (cyc - last_stb < sp_min) sp_min = cyc - last_stb;
            if (cyc - last_stb > sp_max) sp_max = cyc - last_stb;
          end
          in_frame = 1;
        end else if (in_frame) begin
          in_frame = 0;
          frames_done++;
        end
        last_stb = cyc;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: observed no finish, expected finish before timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] crc32(input bq_t d);
    logic [31:0] c = 32'hFFFF_FFFF;
    foreach (d[i]) begin
      c ^= {24'h0, d[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  // reference: byte list from the framing rules, then split into nibbles for MII speeds
  task automatic build_exp(input bq_t pl, input bit tu, input bit mii, input int unf);
    bq_t  by;
    bit   erq[$];
    bit   dcq[$];
    int   n;
    exp_q.delete();
    for (int i = 0; i < 7; i++) begin by.push_back(8'h55); erq.push_back(0); dcq.push_back(0); end
    by.push_back(8'hD5); erq.push_back(0); dcq.push_back(0);
    n = (unf >= 0) ? unf : pl.size();
    for (int i = 0; i < n; i++) begin
      by.push_back(pl[i]); erq.push_back(tu && (i == pl.size() - 1)); dcq.push_back(0);
    end
    if (unf >= 0) begin by.push_back(8'h00); erq.push_back(1); dcq.push_back(1); end
`ifdef GMII_PHY_RX_GEN_FCS_EN
    if (unf < 0) begin
      logic [31:0] c = crc32(pl);
      for (int k = 0; k < 4; k++) begin by.push_back(c[8*k +: 8]); erq.push_back(0); dcq.push_back(0); end
    end
`endif
    for (int i = 0; i < by.size(); i++) begin
      logic [7:0] b = by[i];
      if (mii) begin
        exp_q.push_back('{{4'h0, b[3:0]}, erq[i], dcq[i]});
        exp_q.push_back('{{4'h0, b[7:4]}, erq[i], dcq[i]});
      end else begin
        exp_q.push_back('{b, erq[i], dcq[i]});
      end
    end
  endtask

  task automatic compare_frame(input string tag);
    check({tag, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      if (exp_q[i].dc) check($sformatf("%s_er[%0d]", tag, i), {31'h0, got_q[i].er}, 32'h1);
      else check($sformatf("%s[%0d]", tag, i), {23'h0, got_q[i].rxd, got_q[i].er},
                 {23'h0, exp_q[i].rxd, exp_q[i].er});
    end
  endtask

  task automatic send(input bq_t pl, input bit tu, input int unf);
    int i = 0;
    int g = 0;
    bit dropped = 0;
    while (i < pl.size() && g < 5000) begin
      @(negedge clk);
      g++;
      if (i == unf && !dropped) begin
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tuser = 1'b0;
        if (s_axis_tready) dropped = 1;
      end else begin
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = pl[i];
        s_axis_tlast  = (i == pl.size() - 1);
        s_axis_tuser  = tu && s_axis_tlast;
        if (s_axis_tready) i++;
      end
    end
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tuser = 1'b0;
    check("send_done", i, pl.size());
  endtask

  task automatic wait_frame(input int target, input string tag);
    int g = 0;
    while (frames_done < target && g < 6000) begin @(posedge clk); g++; end
    check(tag, frames_done, target);
  endtask

  task automatic run_frame(input string tag, input bq_t pl, input bit tu, input logic [1:0] spd, input int unf);
    int base = frames_done;
    speed = spd;
    got_q.delete();
    sp_min = 999; sp_max = 0;
    build_exp(pl, tu, spd < 2'b10, unf);
    send(pl, tu, unf);
    wait_frame(base + 1, {tag, "_end"});
    compare_frame(tag);
  endtask

  initial begin
    bq_t pl;
    int  t0, u0, bad, g, base, p;
    logic [1:0] rs;

    repeat (3) @(negedge clk);
    check("reset_outs", {gmii_rxd, gmii_rx_dv, gmii_rx_er, gmii_clk_en, s_axis_tready, busy,
                         error_underflow, mii_select}, 32'h0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_clk_en_1000", gmii_clk_en, 1'b1);

    // 1000M, 01 02 03: 11 dv cycles, then 12 quiet IFG cycles
    pl = '{8'h01, 8'h02, 8'h03};
    t0 = tready_cnt;
    speed = 2'b10; got_q.delete(); sp_min = 999; sp_max = 0;
    build_exp(pl, 0, 0, -1);
    send(pl, 0, -1);
    check("busy_mid", busy, 1'b1);
    wait_frame(1, "g1_end");
    compare_frame("g1");
    check("g1_contig", sp_max, 1);
    bad = 0;
    repeat (11) begin @(negedge clk); if (gmii_rx_dv || s_axis_tready) bad++; end
    check("g1_ifg_quiet", bad, 0);
    check("g1_tready_cnt", tready_cnt - t0, 3);

    // 100M single byte
    pl = '{8'hA5};
    run_frame("m100", pl, 0, 2'b01, -1);
    check("m100_sp_min", sp_min, 5);
    check("m100_sp_max", sp_max, 5);
    check("m100_mii_sel", mii_select, 1'b1);

    // 10M single byte, speed switched to 1000M while the frame is still running
    pl = '{8'h3C};
    base = frames_done;
    speed = 2'b00; got_q.delete(); sp_min = 999; sp_max = 0;
    build_exp(pl, 0, 1, -1);
    send(pl, 0, -1);
    speed = 2'b10;
    wait_frame(base + 1, "m10_end");
    compare_frame("m10");
    check("m10_sp_min", sp_min, 50);
    check("m10_sp_max", sp_max, 50);
    check("m10_mii_sel_hold", mii_select, 1'b1);

    // underflow: byte 2 of 4 missing
    pl = '{8'h11, 8'h22, 8'h33, 8'h44};
    t0 = tready_cnt; u0 = unf_cnt;
    run_frame("unf", pl, 0, 2'b10, 2);
    check("unf_mii_sel", mii_select, 1'b0);
    check("unf_pulses", unf_cnt - u0, 1);
    check("unf_tready_cnt", tready_cnt - t0, 5);
    repeat (2) @(negedge clk);
    check("unf_in_ifg_busy", busy, 1'b1);

    // "123456789"
    pl = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    run_frame("ascii", pl, 0, 2'b10, -1);
`ifdef GMII_PHY_RX_GEN_FCS_EN
    if (got_q.size() >= 21) begin
      check("fcs0", got_q[17].rxd, 8'h26);
      check("fcs1", got_q[18].rxd, 8'h39);
      check("fcs2", got_q[19].rxd, 8'hF4);
      check("fcs3", got_q[20].rxd, 8'hCB);
    end else begin
      check("fcs_len", got_q.size(), 21);
    end
`endif

    // tuser on the last byte
    pl = '{8'hDE, 8'hAD, 8'hBE};
    run_frame("tuser", pl, 1, 2'b10, -1);

    // asynchronous reset during DATA
    speed = 2'b10; got_q.delete();
    @(negedge clk);
    s_axis_tvalid = 1'b1; s_axis_tdata = 8'hAA; s_axis_tlast = 1'b0;
    g = 0;
    while (got_q.size() < 10 && g < 500) begin @(posedge clk); g++; end
    check("rst_reached_data", got_q.size() >= 10, 1'b1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check("rst_mid_outs", {gmii_rxd, gmii_rx_dv, gmii_rx_er, gmii_clk_en, s_axis_tready, busy,
                              error_underflow, mii_select}, 32'h0);
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    pl = '{8'h5A};
    run_frame("post_rst", pl, 0, 2'b10, -1);

    // random frames
    for (int f = 0; f < 10; f++) begin
      pl.delete();
      p = $urandom_range(1, 6);
      for (int i = 0; i < p; i++) pl.push_back(8'($urandom));
      rs = 2'($urandom_range(0, 3));
      repeat ($urandom_range(0, 20)) @(negedge clk);
      run_frame($sformatf("rnd%0d", f), pl, 1'($urandom_range(0, 1)), rs, -1);
      check($sformatf("rnd%0d_mii_sel", f), mii_select, rs < 2'b10);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
